// File: rtl/mem_access_stage.sv
// mem_access_stage
// ----------------
// Data-memory access stage of the 16-bit single-cycle MIPS datapath. It sits
// directly after the execute ALU and adds the LW/SW path. Non-memory results
// pass straight through to the write-back bundle in one cycle. Stores write
// the word-addressed data RAM in one cycle. Loads model a slow memory: they
// hold the upstream PC (stall) for LOAD_LAT cycles before the read data is
// captured.
//
// Parameters:
//   ADDR_W    word-index width; RAM depth is 2**ADDR_W words of 16 bits
//   LOAD_LAT  load wait cycles (1..15) before the read data is captured
//
// Ports:
//   clock         single clock; all state updates on posedge
//   reset         asynchronous, active-high
//   valid_in      upstream instruction present this cycle
//   alu_out       byte address for LW/SW, ALU result otherwise
//   store_data    register read port 2 data, written by SW
//   mem_write     MemWrite control
//   mem_to_reg    MemtoReg control (load)
//   reg_write_in  RegWrite control
//   wr_in         destination register index
//   stall         upstream must hold PC and inputs stable
//   wb_valid      write-back bundle valid
//   wb_data       write-back value
//   wb_wr         write-back register index
//   wb_regwrite   register write enable, already qualified by wb_valid
//   misalign_err  sticky misaligned-access flag
//
// Optional feature (macro MEM_MISALIGN_TRAP_EN):
//   When defined, an LW/SW with alu_out[1:0] != 0 sets misalign_err (sticky
//   until reset). The access is suppressed: a store does not write RAM, and a
//   load does not stall but returns a valid bundle with wb_regwrite low.
//   When undefined, the low address bits are ignored and misalign_err is 0.

module mem_access_stage #(
   parameter int ADDR_W   = 8,
   parameter int LOAD_LAT = 2
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        valid_in,
   input  logic [15:0] alu_out,
   input  logic [15:0] store_data,
   input  logic        mem_write,
   input  logic        mem_to_reg,
   input  logic        reg_write_in,
   input  logic [1:0]  wr_in,
   output logic        stall,
   output logic        wb_valid,
   output logic [15:0] wb_data,
   output logic [1:0]  wb_wr,
   output logic        wb_regwrite,
   output logic        misalign_err
);

   localparam logic [0:0] IDLE      = 1'b0;
   localparam logic [0:0] LOAD_WAIT = 1'b1;

   localparam logic [3:0] LOAD_LAT_M1 = 4'(LOAD_LAT - 1);

   logic [15:0]       ram [0:(1 << ADDR_W) - 1];
   logic [0:0]        state;
   logic [3:0]        wait_cnt;
   logic              wb_regwrite_q;
   logic [ADDR_W-1:0] index;
   logic              misaligned;
   logic              is_store;
   logic              is_load_start;
   logic              unused_addr_bits;

   // Word addressing: the byte offset and the bits above the RAM depth are
   // dropped, so addresses wrap modulo 2**(ADDR_W+2).
   assign index            = alu_out[ADDR_W+1:2];
   assign unused_addr_bits = ^{alu_out[15:ADDR_W+2], alu_out[1:0]};

`ifdef MEM_MISALIGN_TRAP_EN
   assign misaligned = valid_in && (mem_write || mem_to_reg) && (alu_out[1:0] != 2'b00);
`else
   assign misaligned = 1'b0;
`endif

   // A store wins over a simultaneous load request, so a load only starts
   // when MemWrite is low.
   assign is_store      = valid_in && mem_write && !misaligned;
   assign is_load_start = valid_in && mem_to_reg && !mem_write && !misaligned;

   // Stall is raised in the cycle a load is presented and held while the
   // wait counter is non-zero. It drops in the final wait cycle so the
   // upstream advances on the same edge that captures the read data.
   always_comb begin
      stall = 1'b0;
      if (state == IDLE) begin
         stall = is_load_start;
      end else begin
         stall = (wait_cnt != 4'd0);
      end
   end

   // Data RAM write port. The RAM is deliberately not reset.
   always_ff @(posedge clock) begin
      if (!reset && state == IDLE && is_store) begin
         ram[index] <= store_data;
      end
   end

   // Main FSM and write-back bundle. In LOAD_WAIT the inputs are held
   // stable by the stalled upstream, so the index and destination are
   // taken straight from the inputs when the data is captured.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state         <= IDLE;
         wait_cnt      <= 4'd0;
         wb_valid      <= 1'b0;
         wb_data       <= 16'd0;
         wb_wr         <= 2'd0;
         wb_regwrite_q <= 1'b0;
      end else if (state == IDLE) begin
         if (!valid_in) begin
            wb_valid <= 1'b0;
         end else if (is_load_start) begin
            state    <= LOAD_WAIT;
            wait_cnt <= LOAD_LAT_M1;
            wb_valid <= 1'b0;
         end else begin
            wb_data       <= alu_out;
            wb_wr         <= wr_in;
            wb_regwrite_q <= reg_write_in && !mem_write && !misaligned;
            wb_valid      <= 1'b1;
         end
      end else begin
         if (wait_cnt != 4'd0) begin
            wait_cnt <= wait_cnt - 4'd1;
         end else begin
            wb_data       <= ram[index];
            wb_wr         <= wr_in;
            wb_regwrite_q <= reg_write_in;
            wb_valid      <= 1'b1;
            state         <= IDLE;
         end
      end
   end

   // The stored enable may be stale when the bundle is invalid, so it is
   // qualified here rather than cleared on every idle cycle.
   assign wb_regwrite = wb_regwrite_q & wb_valid;

`ifdef MEM_MISALIGN_TRAP_EN
   // Sticky trap flag: set by any misaligned LW/SW accepted in IDLE.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         misalign_err <= 1'b0;
      end else if (state == IDLE && misaligned) begin
         misalign_err <= 1'b1;
      end
   end
`else
   assign misalign_err = 1'b0;
`endif

endmodule
